nkmm_dbus: RTL
==============

// Module: nkmm_dbus
// PURPOSE
//  Data-bus slave for nkmm_cpu; sits directly downstream of the CPU memory I/O stage.
//  Decodes the CPU address, services a local data RAM and a small MMIO window.
//  MMIO exposes an outbound sample FIFO (CPU -> stream), an inbound FIFO (stream -> CPU),
//  status/sticky error bits and a free-running cycle counter.
//  The CPU has no data-bus stall, so every read completes with fixed 1-cycle latency.
// PARAMETERS
//  DRAM_AW  8  data RAM address bits (2**DRAM_AW words of `ACCUM_WIDTH)
//  FIFO_AW  4  FIFO address bits (depth 2**FIFO_AW, both FIFOs)
// PORTS
//  clk          in   1               system clock
//  rst          in   1               asynchronous, active-low reset
//  cpu_addr_i   in   `ADDR_WIDTH     CPU data address (driven every cycle)
//  cpu_data_i   in   `ACCUM_WIDTH    CPU write data
//  cpu_we_i     in   1               CPU write strobe
//  cpu_data_o   out  `ACCUM_WIDTH    read data to CPU, valid cycle after address
//  out_data_o   out  `ACCUM_WIDTH    outbound FIFO head
//  out_valid_o  out  1               outbound FIFO non-empty
//  out_ready_i  in   1               consumer accepts head when valid&ready
//  in_data_i    in   `ACCUM_WIDTH    inbound stream word
//  in_valid_i   in   1               inbound word present
//  in_ready_o   out  1               inbound FIFO can accept
// BEHAVIOUR
//  Map: addr[MSB]=0 -> RAM word addr[DRAM_AW-1:0] (upper bits alias). addr[MSB]=1 -> MMIO by addr[2:0]:
//   0 OUT_PUSH  W: push cpu_data_i to out FIFO. R: 0.
//   1 IN_HEAD   R: in FIFO head (0 if empty). W: pop one word, data ignored.
//   2 STATUS    R: {0.., in_level[FIFO_AW:0], out_level[FIFO_AW:0], in_udf, out_ovf, in_empty, out_full}
//               (bit0 out_full, bit1 in_empty, bit2 out_ovf, bit3 in_udf, levels from bit4). W: W1C bits 2,3.
//   3 CYCLE     R: 32-bit free-running counter zero-extended/truncated to `ACCUM_WIDTH. W: load cpu_data_i.
//   4-7         R: 0. W: ignored.
//  Reads have no side effects (CPU emits no read strobe); all state changes only on cpu_we_i.
//  Read timing: cpu_data_o registered; value for the address presented in cycle N appears in N+1.
//  RAM is read-first: read+write same address same cycle returns old data; next cycle sees new data.
//  Outbound FIFO: out_valid_o = !empty, out_data_o = head (combinational from storage).
//   Pop on out_valid_o&out_ready_i. CPU push when full: accepted only if a pop occurs same cycle,
//   else dropped and out_ovf set. Push+pop on empty: word enqueued, valid next cycle (no bypass).
//  Inbound FIFO: in_ready_o = !full (no same-cycle pass-through); push on in_valid_i&in_ready_o.
//   CPU pop on empty: no-op, in_udf set. Simultaneous push+pop when non-empty: level unchanged.
//  Sticky bits: set and W1C in same cycle -> set wins.
//  CYCLE counter increments every cycle, wraps 2^32-1 -> 0; CPU load takes priority over increment.
//  Pointers wrap modulo depth; levels are FIFO_AW+1 bits so full = 2**FIFO_AW.
//  Reset (async assert, any cycle incl. mid-transfer): FIFOs empty, sticky bits 0, CYCLE 0,
//   cpu_data_o 0, out_valid_o 0, in_ready_o 0 while rst low, 1 from first cycle after release.
//   RAM and FIFO storage contents not reset.
// STRUCTURE
//  nkmm_const.v additions: `DBUS_MMIO_OUT_PUSH, `DBUS_MMIO_IN_HEAD, `DBUS_MMIO_STATUS,
//   `DBUS_MMIO_CYCLE offsets and STATUS bit positions.
//  Sub-module nkmm_sync_fifo (params WIDTH, AW; push/pop/full/empty/level/head), instantiated twice.
//  Top holds address decode, RAM array, read mux register, sticky bits, cycle counter.
// TESTING
//  1 Write RAM[0x05]=0x1234, read 0x05 next cycle -> cpu_data_o=0x1234 one cycle after address.
//  2 Same-cycle write 0xBEEF/read addr 0x07 (old 0x0001) -> returns 0x0001; read again -> 0xBEEF.
//  3 out_ready_i=0, push 17 words (depth 16) -> STATUS bit0=1, bit2=1, out_level=16; W1C 0x4 -> bit2=0.
//  4 Full out FIFO, out_ready_i=1 and push 0xAA same cycle -> level stays 16, no ovf, 0xAA last out.
//  5 Inbound: drive 3 words, read IN_HEAD -> first word; write IN_HEAD x4 -> level 0, in_udf=1.
//  6 Load CYCLE=0xFFFFFFFF -> next read 0x0 (wrap); assert rst mid-stream -> out_valid_o=0 immediately.

Source files
------------

// File: rtl/nkmm_dbus_pkg.sv
// nkmm_dbus shared definitions: bus widths, MMIO offsets, STATUS layout.
// Imported by the data-bus slave and its FIFO sub-module.
package nkmm_dbus_pkg;

   localparam int ADDR_WIDTH  = 16;
   localparam int ACCUM_WIDTH = 32;
   localparam int CYCLE_WIDTH = 32;

   localparam logic [2:0] DBUS_MMIO_OUT_PUSH = 3'd0;
   localparam logic [2:0] DBUS_MMIO_IN_HEAD  = 3'd1;
   localparam logic [2:0] DBUS_MMIO_STATUS   = 3'd2;
   localparam logic [2:0] DBUS_MMIO_CYCLE    = 3'd3;

   localparam int DBUS_ST_OUT_FULL  = 0;
   localparam int DBUS_ST_IN_EMPTY  = 1;
   localparam int DBUS_ST_OUT_OVF   = 2;
   localparam int DBUS_ST_IN_UDF    = 3;
   localparam int DBUS_ST_LEVEL_LSB = 4;

   // One-hot-ish write actions decoded from a single CPU store
   typedef struct packed {
      logic ram_we;
      logic out_push;
      logic in_pop;
      logic w1c_ovf;
      logic w1c_udf;
      logic cyc_load;
   } dbus_wr_t;

endpackage

// File: rtl/nkmm_dbus_fifo.sv
// nkmm_sync_fifo: single-clock FIFO with level counter and combinational head.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module nkmm_sync_fifo
   import nkmm_dbus_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_level,
   output logic             o_push_ok,
   output logic             o_pop_ok
);

   localparam int          DEPTH    = 2**AW;
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_lvl;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full    = (r_lvl == FULL_LVL);
   assign o_empty   = (r_lvl == '0);
   assign o_level   = r_lvl;
   assign o_head    = r_mem[r_rd];
   assign w_pop_ok  = i_pop & ~o_empty;
   assign w_push_ok = i_push & (~o_full | w_pop_ok);
   assign o_push_ok = w_push_ok;
   assign o_pop_ok  = w_pop_ok;

   always_ff @(posedge clk) begin
      if (w_push_ok)
         r_mem[r_wr] <= i_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_lvl <= '0;
      end else begin
         if (w_push_ok)
            r_wr <= r_wr + 1'b1;
         if (w_pop_ok)
            r_rd <= r_rd + 1'b1;
         r_lvl <= r_lvl + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
      end
   end

endmodule

// File: rtl/nkmm_dbus.sv
// nkmm_dbus: CPU data-bus slave with local RAM, stream FIFOs, status and cycle counter.
// Reads are registered; all side effects are tied to cpu_we_i.
module nkmm_dbus
   import nkmm_dbus_pkg::*;
#(
   parameter int DRAM_AW = 8,
   parameter int FIFO_AW = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_WIDTH-1:0]  cpu_addr_i,
   input  logic [ACCUM_WIDTH-1:0] cpu_data_i,
   input  logic                   cpu_we_i,
   output logic [ACCUM_WIDTH-1:0] cpu_data_o,
   output logic [ACCUM_WIDTH-1:0] out_data_o,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   input  logic [ACCUM_WIDTH-1:0] in_data_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o
);

   logic [ACCUM_WIDTH-1:0] r_ram [2**DRAM_AW];
   logic [ACCUM_WIDTH-1:0] r_rdata;
   logic [CYCLE_WIDTH-1:0] r_cycle;
   logic                   r_out_ovf;
   logic                   r_in_udf;

   logic                   w_mmio;
   logic [2:0]             w_off;
   logic [DRAM_AW-1:0]     w_ram_idx;
   dbus_wr_t               w_wr;
   logic [ACCUM_WIDTH-1:0] w_rdata;
   logic [ACCUM_WIDTH-1:0] w_status;

   logic                   w_out_full;
   logic                   w_out_empty;
   logic [FIFO_AW:0]       w_out_level;
   logic                   w_out_push_ok;
   logic                   w_out_pop;
   logic                   w_out_pop_ok;

   logic [ACCUM_WIDTH-1:0] w_in_head;
   logic                   w_in_full;
   logic                   w_in_empty;
   logic [FIFO_AW:0]       w_in_level;
   logic                   w_in_push;
   logic                   w_in_push_ok;
   logic                   w_in_pop_ok;

   logic                   w_ovf_set;
   logic                   w_udf_set;
   logic                   w_unused;

   assign w_mmio    = cpu_addr_i[ADDR_WIDTH-1];
   assign w_off     = cpu_addr_i[2:0];
   assign w_ram_idx = cpu_addr_i[DRAM_AW-1:0];
   assign w_unused  = ^{cpu_addr_i[ADDR_WIDTH-2:DRAM_AW],
                        w_out_pop_ok, w_in_push_ok, w_in_pop_ok};

   always_comb begin
      w_wr = '0;
      if (cpu_we_i) begin
         if (!w_mmio) begin
            w_wr.ram_we = 1'b1;
         end else begin
            case (w_off)
               DBUS_MMIO_OUT_PUSH: w_wr.out_push = 1'b1;
               DBUS_MMIO_IN_HEAD:  w_wr.in_pop   = 1'b1;
               DBUS_MMIO_STATUS: begin
                  w_wr.w1c_ovf = cpu_data_i[DBUS_ST_OUT_OVF];
                  w_wr.w1c_udf = cpu_data_i[DBUS_ST_IN_UDF];
               end
               DBUS_MMIO_CYCLE:    w_wr.cyc_load = 1'b1;
               default: ;
            endcase
         end
      end
   end

   // Handshake outputs are forced low while reset is held
   assign out_valid_o = ~w_out_empty;
   assign w_out_pop   = out_valid_o & out_ready_i;
   assign in_ready_o  = rst & ~w_in_full;
   assign w_in_push   = in_valid_i & in_ready_o;

   nkmm_sync_fifo #(
      .WIDTH (ACCUM_WIDTH),
      .AW    (FIFO_AW)
   ) u_out_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_wr.out_push),
      .i_data    (cpu_data_i),
      .i_pop     (w_out_pop),
      .o_head    (out_data_o),
      .o_full    (w_out_full),
      .o_empty   (w_out_empty),
      .o_level   (w_out_level),
      .o_push_ok (w_out_push_ok),
      .o_pop_ok  (w_out_pop_ok)
   );

   nkmm_sync_fifo #(
      .WIDTH (ACCUM_WIDTH),
      .AW    (FIFO_AW)
   ) u_in_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_in_push),
      .i_data    (in_data_i),
      .i_pop     (w_wr.in_pop),
      .o_head    (w_in_head),
      .o_full    (w_in_full),
      .o_empty   (w_in_empty),
      .o_level   (w_in_level),
      .o_push_ok (w_in_push_ok),
      .o_pop_ok  (w_in_pop_ok)
   );

   assign w_ovf_set = w_wr.out_push & ~w_out_push_ok;
   assign w_udf_set = w_wr.in_pop & w_in_empty;

   assign w_status = ACCUM_WIDTH'({w_in_level, w_out_level,
                                   r_in_udf, r_out_ovf,
                                   w_in_empty, w_out_full});

   always_comb begin
      w_rdata = '0;
      if (!w_mmio) begin
         w_rdata = r_ram[w_ram_idx];
      end else begin
         case (w_off)
            DBUS_MMIO_IN_HEAD: w_rdata = w_in_empty ? '0 : w_in_head;
            DBUS_MMIO_STATUS:  w_rdata = w_status;
            DBUS_MMIO_CYCLE:   w_rdata = ACCUM_WIDTH'(r_cycle);
            default:           w_rdata = '0;
         endcase
      end
   end

   // Read-first RAM: the read register samples the pre-write word
   always_ff @(posedge clk) begin
      if (w_wr.ram_we)
         r_ram[w_ram_idx] <= cpu_data_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdata   <= '0;
         r_cycle   <= '0;
         r_out_ovf <= 1'b0;
         r_in_udf  <= 1'b0;
      end else begin
         r_rdata   <= w_rdata;
         r_cycle   <= w_wr.cyc_load ? CYCLE_WIDTH'(cpu_data_i)
                                    : r_cycle + 1'b1;
         r_out_ovf <= (r_out_ovf & ~w_wr.w1c_ovf) | w_ovf_set;
         r_in_udf  <= (r_in_udf & ~w_wr.w1c_udf) | w_udf_set;
      end
   end

   assign cpu_data_o = r_rdata;

endmodule
